// File: rtl/clk_divider.sv
// ---------------------------------------------------------------------------
// clk_divider
//   Programmable integer clock divider. It divides i_ref_clk by a runtime
//   ratio N and supports both even and odd N. An even N gives a 50% duty
//   cycle. An odd N gives a low phase of (N+1)/2 cycles and a high phase of
//   (N-1)/2 cycles. When the divider is not active, the reference clock is
//   passed straight through.
//
// Ports
//   i_ref_clk    in   reference clock; all state changes on its rising edge
//   i_rst        in   asynchronous active-high reset
//   i_clk_en     in   divider enable; 0 selects bypass
//   i_div_ratio  in   division ratio N (unsigned); N<2 also selects bypass
//   o_div_clk    out  divided clock, or i_ref_clk in bypass
// ---------------------------------------------------------------------------
module clk_divider #(
    parameter int DIV_RATIO_WIDTH = 8
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst,
    input  logic                       i_clk_en,
    input  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio,
    output logic                       o_div_clk
);

    localparam int CW = DIV_RATIO_WIDTH - 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_q, div_d;
    logic          ph_q,  ph_d;

    logic          act;
    logic          odd;
    logic [CW-1:0] half;
    logic [CW-1:0] thr;

    // N >= 2 exactly when any bit above bit 0 is set.
    assign act  = i_clk_en & (|i_div_ratio[DIV_RATIO_WIDTH-1:1]);
    assign odd  = i_div_ratio[0];
    assign half = i_div_ratio[DIV_RATIO_WIDTH-1:1];

    // ph_q is set during the high phase. For odd N the low phase lasts one
    // cycle longer: its threshold is lo-1 = half, and the high phase uses
    // hi-1 = half-1. Even N uses half-1 for both phases. half is at least 1
    // whenever the divider is active, so half-1 never wraps where it is used.
    assign thr = (odd && !ph_q) ? half : (half - CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        ph_d  = ph_q;
        if (!act) begin
            // Hold the state cleared so that enabling starts a low phase.
            cnt_d = '0;
            div_d = 1'b0;
            ph_d  = 1'b0;
        end else if (cnt_q >= thr) begin
            // The >= comparison (not ==) lets a ratio lowered on the fly
            // take effect on the next edge, so the counter never runs away.
            cnt_d = '0;
            div_d = ~div_q;
            ph_d  = ~div_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            ph_q  <= ph_d;
        end
    end

    // Combinational bypass mux. Dropping the enable switches to the
    // reference clock at once, without waiting for a clock edge.
    assign o_div_clk = act ? div_q : i_ref_clk;

endmodule

// File: tb/tb_clk_divider.sv
// ---------------------------------------------------------------------------
// tb_clk_divider
//   Directed bench for clk_divider. It takes expected output levels from
//   closed-form period/phase formulas, queues them when stimulus is driven,
//   and pops and compares them once the DUT has produced the output.
// ---------------------------------------------------------------------------
module tb_clk_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] ratio;
    logic       out;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    clk_divider #(.DIV_RATIO_WIDTH(8)) dut (
        .i_ref_clk  (clk),
        .i_rst      (rst),
        .i_clk_en   (en),
        .i_div_ratio(ratio),
        .o_div_clk  (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag);
        logic e;
        e = exp_q.pop_front();
        checks++;
        assert (out === e) else begin
            errors++;
            $error("FAIL %s obs=%0b exp=%0b t=%0t", tag, out, e, $time);
        end
    endtask

    // Bypass: the output equals the reference clock in both phases.
    task automatic bypass(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back(1'b1);
            @(posedge clk); #1; chk(tag);
            exp_q.push_back(1'b0);
            @(negedge clk); #1; chk(tag);
        end
    endtask

    // Fresh start from the cleared state. After rising edge k (k >= 1) the
    // output is 0 for k < lo, and otherwise 1 iff (k-lo) mod N < hi.
    task automatic div_fresh(input string tag, input int n, input int cycles);
        int lo, hi;
        lo = (n + 1) / 2;
        hi = n - lo;
        @(negedge clk); en = 1'b0; ratio = 8'(n);
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= cycles; k++) begin
            exp_q.push_back((k >= lo) && (((k - lo) % n) < hi));
            @(posedge clk); #1; chk(tag);
        end
    endtask

    // Ratio change on the fly. Wait for the next rising output, then expect
    // a steady pattern: after edge j past that rise, out = (j mod N) < hi.
    task automatic div_sync(input string tag, input int n, input int cycles);
        int   hi;
        logic prev;
        bit   seen;
        hi = n - (n + 1) / 2;
        @(negedge clk); ratio = 8'(n);
        prev = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 600 && !seen; t++) begin
            @(posedge clk); #1;
            if (!prev && out) seen = 1'b1;
            prev = out;
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout obs=no_rise exp=rise", tag);
        end else begin
            for (int j = 1; j <= cycles; j++) begin
                exp_q.push_back((j % n) < hi);
                @(posedge clk); #1; chk(tag);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ratio = 8'd0;
        // Reset state: even with the divider active, div_q is held at 0.
        @(negedge clk); en = 1'b1; ratio = 8'd2; #1;
        exp_q.push_back(1'b0); chk("reset_neg");
        @(posedge clk); #1;
        exp_q.push_back(1'b0); chk("reset_pos");
        @(negedge clk); en = 1'b0; ratio = 8'd0; rst = 1'b0;
        bypass("bypass_n0", 5);

        div_fresh("div2", 2, 20);
        div_sync("div4", 4, 40);
        div_sync("div3", 3, 30);
        div_sync("div5", 5, 50);   // ends on a high level (50 % 5 == 0)

        // Reset mid-operation clears div_q at once.
        #2 rst = 1'b1; #1;
        exp_q.push_back(1'b0); chk("rst_mid");
        @(negedge clk); rst = 1'b0;

        // N=1 with enable set behaves like bypass.
        en = 1'b1; ratio = 8'd1;
        bypass("bypass_n1", 5);

        div_fresh("div255", 255, 2 * 255 + 10);

        // Drop enable in a high phase: the output follows the reference
        // clock immediately, and re-enabling restarts from low.
        div_sync("div4_pre", 4, 8);  // ends just after a rise
        en = 1'b0;
        exp_q.push_back(1'b0);
        @(negedge clk); #1; chk("en_drop_neg");
        exp_q.push_back(1'b1);
        @(posedge clk); #1; chk("en_drop_pos");
        div_fresh("div4_reen", 4, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
